// File: rtl/tlc_pkg.sv
// Shared types and constants for the two-road traffic-light controller.
package tlc_pkg;

  // Controller phases: all-red before highway, highway green/yellow,
  // all-red before farm, farm green/yellow.
  typedef enum logic [2:0] {
    S_ARH = 3'd0,
    S_HG  = 3'd1,
    S_HY  = 3'd2,
    S_ARF = 3'd3,
    S_FG  = 3'd4,
    S_FY  = 3'd5
  } tlc_state_e;

  // Signal-head encoding shared by both roads.
  localparam logic [1:0] SIG_GREEN  = 2'b00;
  localparam logic [1:0] SIG_YELLOW = 2'b01;
  localparam logic [1:0] SIG_RED    = 2'b10;

  // A farm vehicle may only raise a new request outside the farm all-red and
  // farm-green phases, so a held sensor cannot extend a capped green forever.
  function automatic logic canRequest(input tlc_state_e s);
    return (s == S_ARH) || (s == S_HG) || (s == S_HY) || (s == S_FY);
  endfunction

endpackage

// File: rtl/tlc_sync.sv
// Multi-flop synchronizer for a single asynchronous input bit.
module tlc_sync #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  if (DEPTH < 2) begin : gBadDepth
    $fatal(1, "tlc_sync: DEPTH must be at least 2");
  end

  logic [DEPTH-1:0] stage_q;

  // Shift the raw input through the flop chain; the last stage is the clean copy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[DEPTH-2:0], d_i};
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/tlc_controller_v2.sv
// Highway/farm traffic-light controller with per-phase timers, a latched farm
// request and a sensor-extended farm green capped at T_FARM_MAX cycles.
// Optional debug tap enabled by defining TLC_DEBUG_EN.
module tlc_controller_v2
  import tlc_pkg::*;
#(
  parameter int unsigned CNT_W      = 31,
  parameter int unsigned T_ALLRED   = 2,
  parameter int unsigned T_YELLOW   = 3,
  parameter int unsigned T_HWY_MIN  = 8,
  parameter int unsigned T_FARM_MIN = 4,
  parameter int unsigned T_FARM_MAX = 10
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       farmSensor,
  output logic [1:0] highwaySignal,
  output logic [1:0] farmSignal,
  output logic       farmWaiting,
  output logic [3:0] dbg
);

  localparam longint unsigned CNT_LIMIT = 64'd1 << CNT_W;

  if (T_ALLRED < 1 || T_YELLOW < 1 || T_HWY_MIN < 1 || T_FARM_MIN < 1 || T_FARM_MAX < 1) begin : gBadDwell
    $fatal(1, "tlc_controller_v2: every dwell parameter must be at least 1");
  end
  if (T_FARM_MIN > T_FARM_MAX) begin : gBadFarm
    $fatal(1, "tlc_controller_v2: T_FARM_MIN must not exceed T_FARM_MAX");
  end
  if (longint'(T_ALLRED) >= CNT_LIMIT || longint'(T_YELLOW) >= CNT_LIMIT ||
      longint'(T_HWY_MIN) >= CNT_LIMIT || longint'(T_FARM_MIN) >= CNT_LIMIT ||
      longint'(T_FARM_MAX) >= CNT_LIMIT) begin : gBadWidth
    $fatal(1, "tlc_controller_v2: a dwell does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] ALLRED_LAST   = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST   = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] HWY_MIN_LAST  = CNT_W'(T_HWY_MIN - 1);
  localparam logic [CNT_W-1:0] FARM_MIN_LAST = CNT_W'(T_FARM_MIN - 1);
  localparam logic [CNT_W-1:0] FARM_MAX_LAST = CNT_W'(T_FARM_MAX - 1);

  tlc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             farmWaiting_q, farmWaiting_d;
  logic             sensSync;
  logic             cntClear;

  tlc_sync #(.DEPTH(2)) uSensSync (
    .clk_i  (Clk),
    .rst_ni (Rst),
    .d_i    (farmSensor),
    .q_o    (sensSync)
  );

  // Phase sequencing: each phase exits on its timer, highway green also waits for a request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_ARH:   if (cnt_q == ALLRED_LAST) state_d = S_HG;
      S_HG:    if (cnt_q >= HWY_MIN_LAST && farmWaiting_q) state_d = S_HY;
      S_HY:    if (cnt_q == YELLOW_LAST) state_d = S_ARF;
      S_ARF:   if (cnt_q == ALLRED_LAST) state_d = S_FG;
      S_FG:    if (cnt_q == FARM_MAX_LAST || (cnt_q >= FARM_MIN_LAST && !sensSync)) state_d = S_FY;
      S_FY:    if (cnt_q == YELLOW_LAST) state_d = S_ARH;
      default: state_d = S_ARH;
    endcase
  end

  // Phase timer restarts on every phase change and parks once highway green has served its minimum.
  always_comb begin
    cntClear = (state_d != state_q);
    if (cntClear) begin
      cnt_d = '0;
    end else if (state_q == S_HG && cnt_q >= HWY_MIN_LAST) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Farm request latch: serving the farm (entering farm green) takes priority over a new request.
  always_comb begin
    farmWaiting_d = farmWaiting_q;
    if (state_d == S_FG && state_q != S_FG) begin
      farmWaiting_d = 1'b0;
    end else if (sensSync && canRequest(state_q)) begin
      farmWaiting_d = 1'b1;
    end
  end

  // State, timer and request registers; reset forces the all-red phase at once.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q       <= S_ARH;
      cnt_q         <= '0;
      farmWaiting_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      farmWaiting_q <= farmWaiting_d;
    end
  end

  // Signal heads decode straight from the state so at most one head is ever non-red.
  always_comb begin
    highwaySignal = SIG_RED;
    farmSignal    = SIG_RED;
    case (state_q)
      S_HG:    highwaySignal = SIG_GREEN;
      S_HY:    highwaySignal = SIG_YELLOW;
      S_FG:    farmSignal    = SIG_GREEN;
      S_FY:    farmSignal    = SIG_YELLOW;
      default: ;
    endcase
  end

  assign farmWaiting = farmWaiting_q;

`ifdef TLC_DEBUG_EN
  assign dbg = {cntClear, state_q};
`else
  assign dbg = 4'b0000;
`endif

endmodule
